// File: rtl/matmul_sequencer.sv
// Matrix-multiply sequencer: latches A and B, then walks C row-major by time-sharing
// one external dot_product unit and streaming each C[i][j] out over valid/ready.
module matmul_sequencer #(
   parameter int M       = 2,
   parameter int K       = 2,
   parameter int P       = 2,
   parameter int DW      = 8,
   parameter int SW      = 32,
   parameter int TIMEOUT = 64,
   localparam int RW     = (M > 1) ? $clog2(M) : 1,
   localparam int CW     = (P > 1) ? $clog2(P) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [M*K*DW-1:0] mat_a,
   input  logic [K*P*DW-1:0] mat_b,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              dp_start,
   output logic [K*DW-1:0]   dp_inp1,
   output logic [K*DW-1:0]   dp_inp2,
   input  logic [SW-1:0]     dp_sum,
   input  logic              dp_valid,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [RW-1:0]     res_row,
   output logic [CW-1:0]     res_col,
   output logic [SW-1:0]     res_data
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      WRITE,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [M*K*DW-1:0]   matA_q, matA_d;
   logic [K*P*DW-1:0]   matB_q, matB_d;
   logic [RW-1:0]       rowIdx_q, rowIdx_d;
   logic [CW-1:0]       colIdx_q, colIdx_d;
   logic [TW-1:0]       waitCnt_q, waitCnt_d;
   logic                error_q, error_d;
   logic [SW-1:0]       resData_q, resData_d;
   logic [RW-1:0]       resRow_q, resRow_d;
   logic [CW-1:0]       resCol_q, resCol_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         matA_q    <= '0;
         matB_q    <= '0;
         rowIdx_q  <= '0;
         colIdx_q  <= '0;
         waitCnt_q <= '0;
         error_q   <= 1'b0;
         resData_q <= '0;
         resRow_q  <= '0;
         resCol_q  <= '0;
      end else begin
         state_q   <= state_d;
         matA_q    <= matA_d;
         matB_q    <= matB_d;
         rowIdx_q  <= rowIdx_d;
         colIdx_q  <= colIdx_d;
         waitCnt_q <= waitCnt_d;
         error_q   <= error_d;
         resData_q <= resData_d;
         resRow_q  <= resRow_d;
         resCol_q  <= resCol_d;
      end
   end

   // In WAIT a valid result beats the timeout, so a reply on the last allowed cycle is kept.
   always_comb begin
      state_d   = state_q;
      matA_d    = matA_q;
      matB_d    = matB_q;
      rowIdx_d  = rowIdx_q;
      colIdx_d  = colIdx_q;
      waitCnt_d = waitCnt_q;
      error_d   = error_q;
      resData_d = resData_q;
      resRow_d  = resRow_q;
      resCol_d  = resCol_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               matA_d   = mat_a;
               matB_d   = mat_b;
               rowIdx_d = '0;
               colIdx_d = '0;
               error_d  = 1'b0;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            waitCnt_d = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            if (dp_valid) begin
               resData_d = dp_sum;
               resRow_d  = rowIdx_q;
               resCol_d  = colIdx_q;
               state_d   = WRITE;
            end else if (waitCnt_q == TW'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = DONE;
            end else begin
               waitCnt_d = waitCnt_q + TW'(1);
            end
         end
         WRITE: begin
            if (res_ready) begin
               if (rowIdx_q == RW'(M - 1) && colIdx_q == CW'(P - 1)) begin
                  state_d = DONE;
               end else begin
                  if (colIdx_q == CW'(P - 1)) begin
                     colIdx_d = '0;
                     rowIdx_d = rowIdx_q + RW'(1);
                  end else begin
                     colIdx_d = colIdx_q + CW'(1);
                  end
                  state_d = ISSUE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Row i of A is contiguous in the packed operand; column j of B has to be gathered.
   always_comb begin
      dp_inp1 = matA_q[int'(rowIdx_q)*K*DW +: K*DW];
      dp_inp2 = '0;
      for (int k = 0; k < K; k++) begin
         dp_inp2[k*DW +: DW] = matB_q[(k*P + int'(colIdx_q))*DW +: DW];
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign dp_start  = (state_q == ISSUE);
   assign res_valid = (state_q == WRITE);
   assign error     = error_q;
   assign res_data  = resData_q;
   assign res_row   = resRow_q;
   assign res_col   = resCol_q;

endmodule
